// File: rtl/ethernet_pkg.sv
// Shared definitions for the receive-side Ethernet/IPv4/UDP header path:
// field byte offsets, protocol constants, drop-reason codes, parser FSM states.
package ethernet_pkg;

    // Captured header geometry: byte k sits at bits [HDR_MSB-8k -: 8]
    localparam int HDR_BYTES = 42;
    localparam int HDR_W     = 8 * HDR_BYTES;
    localparam int HDR_MSB   = HDR_W - 1;

    // Field byte offsets within the frame
    localparam int ETH_DST   = 0;
    localparam int ETH_SRC   = 6;
    localparam int ETH_TYPE  = 12;
    localparam int IP_BASE   = 14;
    localparam int IP_TOTLEN = 16;
    localparam int IP_FRAG   = 20;
    localparam int IP_PROTO  = 23;
    localparam int IP_SRC    = 26;
    localparam int IP_DST    = 30;
    localparam int UDP_BASE  = 34;
    localparam int UDP_DPORT = 36;
    localparam int UDP_LEN   = 38;

    // The IPv4 header (no options) is 10 words, summed two per cycle
    localparam int IP_WORDS   = 10;
    localparam int SUM_CYCLES = IP_WORDS / 2;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;

    // Drop reasons; lower code has priority when several checks fail
    localparam logic [3:0] DROP_NONE     = 4'd0;
    localparam logic [3:0] DROP_MAC      = 4'd1;
    localparam logic [3:0] DROP_TYPE     = 4'd2;
    localparam logic [3:0] DROP_VER_IHL  = 4'd3;
    localparam logic [3:0] DROP_CHECKSUM = 4'd4;
    localparam logic [3:0] DROP_FRAGMENT = 4'd5;
    localparam logic [3:0] DROP_PROTO    = 4'd6;
    localparam logic [3:0] DROP_DST_IP   = 4'd7;
    localparam logic [3:0] DROP_PORT     = 4'd8;
    localparam logic [3:0] DROP_LENGTH   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUM  = 2'd1,
        ST_FOLD = 2'd2
    } parse_state_e;

endpackage

// File: rtl/ip_checksum_accum.sv
// IPv4 one's-complement checksum accumulator. Adds two 16-bit words per
// enabled cycle into a 20-bit accumulator (headroom for 10 words without
// wrap), then folds the carries end-around. ok_o is qualified by done_i.
module ip_checksum_accum (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic        done_i,
    input  logic [15:0] word_a_i,
    input  logic [15:0] word_b_i,
    output logic        ok_o
);

    logic [19:0] acc_q;
    logic [16:0] fold_s;
    logic [15:0] fold_c;

    // Accumulate two words per enabled cycle; clear takes priority
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc_q <= 20'd0;
        end else if (clear_i) begin
            acc_q <= 20'd0;
        end else if (en_i) begin
            acc_q <= acc_q + {4'd0, word_a_i} + {4'd0, word_b_i};
        end
    end

    // Two-step end-around fold; the second step cannot carry again
    always_comb begin
        fold_s = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
        fold_c = fold_s[15:0] + {15'd0, fold_s[16]};
        ok_o   = done_i && (fold_c == 16'hFFFF);
    end

endmodule

// File: rtl/ethernet_header_parser.sv
// Parses a captured 42-byte Ethernet II + IPv4 + UDP header, verifies the
// IPv4 checksum and consistency checks, and emits one registered verdict
// (accept or first failing reason) with the parsed fields per header.
// Handshake: i_data_head_valid is a one-cycle pulse with no backpressure;
// it is taken only in IDLE, otherwise the header is dropped and o_overrun
// pulses one cycle later. o_hdr_valid is a one-cycle strobe qualifying
// o_hdr_accept/o_drop_reason; field outputs hold until the next verdict.
module ethernet_header_parser
    import ethernet_pkg::*;
#(
    parameter bit P_ACCEPT_BROADCAST = 1'b1,
    parameter bit P_CHECK_UDP_PORT   = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [335:0] i_data_head,
    input  logic         i_data_head_valid,
    input  logic [47:0]  i_local_mac,
    input  logic [31:0]  i_local_ip,
    input  logic [15:0]  i_local_port,
    output logic         o_hdr_valid,
    output logic         o_hdr_accept,
    output logic [3:0]   o_drop_reason,
    output logic [47:0]  o_src_mac,
    output logic [31:0]  o_src_ip,
    output logic [15:0]  o_src_port,
    output logic [15:0]  o_dst_port,
    output logic [15:0]  o_payload_len,
    output logic         o_busy,
    output logic         o_overrun
);

    parse_state_e state_q, state_d;
    logic [2:0]   wc_q, wc_d;
    logic         capture, acc_clear, acc_en, csum_ok;
    logic [15:0]  word_a, word_b;

    logic [335:0] hdr_q;
    logic [47:0]  mac_q;
    logic [31:0]  ip_q;
    logic [15:0]  port_q;

    logic         hdr_valid_q, accept_q, overrun_q;
    logic [3:0]   reason_q, reason_d;
    logic [47:0]  src_mac_q;
    logic [31:0]  src_ip_q;
    logic [15:0]  src_port_q, dst_port_q, payload_len_q;

    // Fields of the latched header
    logic [47:0] f_dst_mac, f_src_mac;
    logic [15:0] f_type, f_ip_len, f_frag, f_sport, f_dport, f_udp_len;
    logic [7:0]  f_ver_ihl, f_proto;
    logic [31:0] f_src_ip, f_dst_ip;
    logic        mac_ok, len_bad, unused_udp_csum;

    assign f_dst_mac = hdr_q[HDR_MSB - 8*ETH_DST   -: 48];
    assign f_src_mac = hdr_q[HDR_MSB - 8*ETH_SRC   -: 48];
    assign f_type    = hdr_q[HDR_MSB - 8*ETH_TYPE  -: 16];
    assign f_ver_ihl = hdr_q[HDR_MSB - 8*IP_BASE   -: 8];
    assign f_ip_len  = hdr_q[HDR_MSB - 8*IP_TOTLEN -: 16];
    assign f_frag    = hdr_q[HDR_MSB - 8*IP_FRAG   -: 16];
    assign f_proto   = hdr_q[HDR_MSB - 8*IP_PROTO  -: 8];
    assign f_src_ip  = hdr_q[HDR_MSB - 8*IP_SRC    -: 32];
    assign f_dst_ip  = hdr_q[HDR_MSB - 8*IP_DST    -: 32];
    assign f_sport   = hdr_q[HDR_MSB - 8*UDP_BASE  -: 16];
    assign f_dport   = hdr_q[HDR_MSB - 8*UDP_DPORT -: 16];
    assign f_udp_len = hdr_q[HDR_MSB - 8*UDP_LEN   -: 16];
    // UDP checksum is not verified here; the payload handler owns it
    assign unused_udp_csum = ^hdr_q[15:0];

    assign o_busy = (state_q != ST_IDLE);

    // FSM state register and word counter
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            wc_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
        end
    end

    // FSM next state: capture in IDLE, five sum cycles, one fold/verdict cycle
    always_comb begin
        state_d   = state_q;
        wc_d      = wc_q;
        capture   = 1'b0;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_data_head_valid) begin
                    capture   = 1'b1;
                    acc_clear = 1'b1;
                    wc_d      = 3'd0;
                    state_d   = ST_SUM;
                end
            end
            ST_SUM: begin
                acc_en = 1'b1;
                wc_d   = wc_q + 3'd1;
                if (wc_q == 3'(SUM_CYCLES - 1)) begin
                    wc_d    = 3'd0;
                    state_d = ST_FOLD;
                end
            end
            ST_FOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch header and local configuration at capture
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hdr_q  <= '0;
            mac_q  <= '0;
            ip_q   <= '0;
            port_q <= '0;
        end else if (capture) begin
            hdr_q  <= i_data_head;
            mac_q  <= i_local_mac;
            ip_q   <= i_local_ip;
            port_q <= i_local_port;
        end
    end

    // Select IP words 2*wc and 2*wc+1 for this sum cycle
    always_comb begin
        word_a = 16'd0;
        word_b = 16'd0;
        for (int i = 0; i < SUM_CYCLES; i++) begin
            if (wc_q == 3'(i)) begin
                word_a = hdr_q[HDR_MSB - 8*(IP_BASE + 4*i)     -: 16];
                word_b = hdr_q[HDR_MSB - 8*(IP_BASE + 4*i + 2) -: 16];
            end
        end
    end

    ip_checksum_accum u_csum (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .clear_i  (acc_clear),
        .en_i     (acc_en),
        .done_i   (state_q == ST_FOLD),
        .word_a_i (word_a),
        .word_b_i (word_b),
        .ok_o     (csum_ok)
    );

    // Prioritised checks; the lowest failing code is reported
    always_comb begin
        mac_ok  = (f_dst_mac == mac_q) ||
                  (P_ACCEPT_BROADCAST && (f_dst_mac == 48'hFFFF_FFFF_FFFF));
        len_bad = (f_udp_len < 16'd8) ||
                  ({1'b0, f_ip_len} != ({1'b0, f_udp_len} + 17'd20));
        reason_d = DROP_NONE;
        if (!mac_ok)                                   reason_d = DROP_MAC;
        else if (f_type != ETHERTYPE_IPV4)             reason_d = DROP_TYPE;
        else if (f_ver_ihl != IP_VER_IHL)              reason_d = DROP_VER_IHL;
        else if (!csum_ok)                             reason_d = DROP_CHECKSUM;
        else if (f_frag[13] || (f_frag[12:0] != 13'd0)) reason_d = DROP_FRAGMENT;
        else if (f_proto != IP_PROTO_UDP)              reason_d = DROP_PROTO;
        else if (f_dst_ip != ip_q)                     reason_d = DROP_DST_IP;
        else if (P_CHECK_UDP_PORT && (f_dport != port_q)) reason_d = DROP_PORT;
        else if (len_bad)                              reason_d = DROP_LENGTH;
    end

    // Verdict and field outputs, registered in the fold cycle; strobes otherwise 0
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hdr_valid_q   <= 1'b0;
            accept_q      <= 1'b0;
            reason_q      <= DROP_NONE;
            src_mac_q     <= '0;
            src_ip_q      <= '0;
            src_port_q    <= '0;
            dst_port_q    <= '0;
            payload_len_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            hdr_valid_q <= (state_q == ST_FOLD);
            overrun_q   <= i_data_head_valid && (state_q != ST_IDLE);
            if (state_q == ST_FOLD) begin
                accept_q      <= (reason_d == DROP_NONE);
                reason_q      <= reason_d;
                src_mac_q     <= f_src_mac;
                src_ip_q      <= f_src_ip;
                src_port_q    <= f_sport;
                dst_port_q    <= f_dport;
                payload_len_q <= f_udp_len - 16'd8;
            end
        end
    end

    assign o_hdr_valid   = hdr_valid_q;
    assign o_hdr_accept  = accept_q;
    assign o_drop_reason = reason_q;
    assign o_src_mac     = src_mac_q;
    assign o_src_ip      = src_ip_q;
    assign o_src_port    = src_port_q;
    assign o_dst_port    = dst_port_q;
    assign o_payload_len = payload_len_q;
    assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_ethernet_header_parser.sv
// Bench for ethernet_header_parser: directed cases plus randomized headers,
// scored against a byte-level reference model. Two instances cover both
// parameter settings (A: defaults, B: no broadcast, no UDP port check).
module tb_ethernet_header_parser;

    typedef struct {
        logic [47:0] dst_mac, src_mac;
        logic [15:0] etype;
        logic [7:0]  ver_ihl, tos;
        logic [15:0] ip_len, id, frag;
        logic [7:0]  ttl, proto;
        logic [15:0] csum;
        logic [31:0] src_ip, dst_ip;
        logic [15:0] sport, dport, ulen, ucsum;
    } pkt_t;

    typedef struct {
        logic [3:0]  reason;
        logic [47:0] src_mac;
        logic [31:0] src_ip;
        logic [15:0] sport, dport, plen;
        int          cyc;
    } verdict_t;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    logic i_reset;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    logic [335:0] i_data_head;
    logic         i_data_head_valid;
    logic [47:0]  i_local_mac;
    logic [31:0]  i_local_ip;
    logic [15:0]  i_local_port;

    logic        vld_a, acc_a, busy_a, ovr_a, vld_b, acc_b, busy_b, ovr_b;
    logic [3:0]  rsn_a, rsn_b;
    logic [47:0] smac_a, smac_b;
    logic [31:0] sip_a, sip_b;
    logic [15:0] sport_a, dport_a, plen_a, sport_b, dport_b, plen_b;

    ethernet_header_parser dut_a (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_data_head(i_data_head), .i_data_head_valid(i_data_head_valid),
        .i_local_mac(i_local_mac), .i_local_ip(i_local_ip), .i_local_port(i_local_port),
        .o_hdr_valid(vld_a), .o_hdr_accept(acc_a), .o_drop_reason(rsn_a),
        .o_src_mac(smac_a), .o_src_ip(sip_a), .o_src_port(sport_a), .o_dst_port(dport_a),
        .o_payload_len(plen_a), .o_busy(busy_a), .o_overrun(ovr_a)
    );

    ethernet_header_parser #(.P_ACCEPT_BROADCAST(1'b0), .P_CHECK_UDP_PORT(1'b0)) dut_b (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_data_head(i_data_head), .i_data_head_valid(i_data_head_valid),
        .i_local_mac(i_local_mac), .i_local_ip(i_local_ip), .i_local_port(i_local_port),
        .o_hdr_valid(vld_b), .o_hdr_accept(acc_b), .o_drop_reason(rsn_b),
        .o_src_mac(smac_b), .o_src_ip(sip_b), .o_src_port(sport_b), .o_dst_port(dport_b),
        .o_payload_len(plen_b), .o_busy(busy_b), .o_overrun(ovr_b)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [335:0] pack(input pkt_t p);
        return {p.dst_mac, p.src_mac, p.etype, p.ver_ihl, p.tos, p.ip_len, p.id, p.frag,
                p.ttl, p.proto, p.csum, p.src_ip, p.dst_ip, p.sport, p.dport, p.ulen, p.ucsum};
    endfunction

    function automatic logic [15:0] ip_csum(input pkt_t p);
        int unsigned s;
        s = {p.ver_ihl, p.tos} + p.ip_len + p.id + p.frag + {p.ttl, p.proto}
            + p.src_ip[31:16] + p.src_ip[15:0] + p.dst_ip[31:16] + p.dst_ip[15:0];
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    function automatic verdict_t model(input logic [335:0] h, input logic [47:0] mac,
                                       input logic [31:0] ip, input logic [15:0] port,
                                       input bit bcast, input bit chk_port);
        logic [7:0]  b [42];
        logic [47:0] dmac, smac;
        int unsigned s;
        int          ip_len, ulen;
        logic [15:0] frag;
        verdict_t    v;
        for (int k = 0; k < 42; k++) b[k] = h[335 - 8*k -: 8];
        dmac = '0; smac = '0;
        for (int k = 0; k < 6; k++) begin
            dmac = (dmac << 8) | 48'(b[k]);
            smac = (smac << 8) | 48'(b[6 + k]);
        end
        s = 0;
        for (int i = 0; i < 10; i++) s += {b[14 + 2*i], b[15 + 2*i]};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        ip_len = int'({b[16], b[17]});
        ulen   = int'({b[38], b[39]});
        frag   = {b[20], b[21]};
        if (!(dmac == mac || (bcast && dmac == 48'hFFFF_FFFF_FFFF)))  v.reason = 1;
        else if ({b[12], b[13]} != 16'h0800)                          v.reason = 2;
        else if (b[14] != 8'h45)                                      v.reason = 3;
        else if (s != 32'hFFFF)                                       v.reason = 4;
        else if (frag[13] || frag[12:0] != 0)                         v.reason = 5;
        else if (b[23] != 8'h11)                                      v.reason = 6;
        else if ({b[30], b[31], b[32], b[33]} != ip)                  v.reason = 7;
        else if (chk_port && {b[36], b[37]} != port)                  v.reason = 8;
        else if (ulen < 8 || ip_len != ulen + 20)                     v.reason = 9;
        else                                                          v.reason = 0;
        v.src_mac = smac;
        v.src_ip  = {b[26], b[27], b[28], b[29]};
        v.sport   = {b[34], b[35]};
        v.dport   = {b[36], b[37]};
        v.plen    = 16'(ulen - 8);
        v.cyc     = 0;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    verdict_t exp_a_q[$];
    verdict_t exp_b_q[$];
    int       exp_ovr_a_q[$];
    int       exp_ovr_b_q[$];

    // Verdict/overrun monitor, sampled on the falling edge
    always @(negedge i_clk) begin
        verdict_t v;
        if (!i_reset) begin
            if (vld_a) begin
                if (exp_a_q.size() == 0) check_eq("spurious_verdict_a", vld_a, 0);
                else begin
                    v = exp_a_q.pop_front();
                    check_eq("latency_a", cyc, v.cyc);
                    check_eq("reason_a", rsn_a, v.reason);
                    check_eq("accept_a", acc_a, v.reason == 0);
                    check_eq("src_mac_a", smac_a, v.src_mac);
                    check_eq("src_ip_a", sip_a, v.src_ip);
                    check_eq("src_port_a", sport_a, v.sport);
                    check_eq("dst_port_a", dport_a, v.dport);
                    if (v.reason == 0) check_eq("payload_len_a", plen_a, v.plen);
                end
            end
            if (vld_b) begin
                if (exp_b_q.size() == 0) check_eq("spurious_verdict_b", vld_b, 0);
                else begin
                    v = exp_b_q.pop_front();
                    check_eq("latency_b", cyc, v.cyc);
                    check_eq("reason_b", rsn_b, v.reason);
                    check_eq("accept_b", acc_b, v.reason == 0);
                    check_eq("src_ip_b", sip_b, v.src_ip);
                    if (v.reason == 0) check_eq("payload_len_b", plen_b, v.plen);
                end
            end
            if (ovr_a) begin
                if (exp_ovr_a_q.size() == 0) check_eq("spurious_overrun_a", ovr_a, 0);
                else check_eq("overrun_cycle_a", cyc, exp_ovr_a_q.pop_front());
            end
            if (ovr_b) begin
                if (exp_ovr_b_q.size() == 0) check_eq("spurious_overrun_b", ovr_b, 0);
                else check_eq("overrun_cycle_b", cyc, exp_ovr_b_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; pulses valid for one cycle. If accepted,
    // expects a verdict 7 cycles later, otherwise an overrun 1 cycle later.
    task automatic pulse(input logic [335:0] h, input bit expect_verdict);
        verdict_t va, vb;
        i_data_head       = h;
        i_data_head_valid = 1'b1;
        if (expect_verdict) begin
            va = model(h, i_local_mac, i_local_ip, i_local_port, 1'b1, 1'b1);
            vb = model(h, i_local_mac, i_local_ip, i_local_port, 1'b0, 1'b0);
            va.cyc = cyc + 7;
            vb.cyc = cyc + 7;
            exp_a_q.push_back(va);
            exp_b_q.push_back(vb);
        end else begin
            exp_ovr_a_q.push_back(cyc + 1);
            exp_ovr_b_q.push_back(cyc + 1);
        end
        @(negedge i_clk);
        i_data_head_valid = 1'b0;
        for (int i = 0; i < 11; i++) i_data_head[32*i +: 32] = $urandom();
    endtask

    task automatic scramble_locals();
        i_local_mac  = 48'({$urandom(), $urandom()});
        i_local_ip   = $urandom();
        i_local_port = 16'($urandom());
    endtask

    function automatic pkt_t plan_pkt();
        pkt_t p;
        p.dst_mac = 48'h02_00_00_00_00_01; p.src_mac = 48'h02_00_00_00_00_02;
        p.etype = 16'h0800; p.ver_ihl = 8'h45; p.tos = 8'h00; p.ip_len = 16'h0073;
        p.id = 16'h0000; p.frag = 16'h4000; p.ttl = 8'h40; p.proto = 8'h11;
        p.csum = 16'hB861; p.src_ip = 32'hC0A8_0001; p.dst_ip = 32'hC0A8_00C7;
        p.sport = 16'h5555; p.dport = 16'h1234; p.ulen = 16'h005F; p.ucsum = 16'h0000;
        return p;
    endfunction

    function automatic pkt_t rand_pkt(input logic [47:0] mac, input logic [31:0] ip,
                                      input logic [15:0] port);
        pkt_t p;
        p.dst_mac = mac; p.src_mac = 48'({$urandom(), $urandom()});
        p.etype = 16'h0800; p.ver_ihl = 8'h45; p.tos = 8'($urandom());
        p.ulen = 16'($urandom_range(8, 1472)); p.ip_len = p.ulen + 16'd20;
        p.id = 16'($urandom()); p.frag = ($urandom_range(0, 1) != 0) ? 16'h4000 : 16'h0000;
        p.ttl = 8'($urandom_range(1, 255)); p.proto = 8'h11; p.csum = 16'h0;
        p.src_ip = $urandom(); p.dst_ip = ip; p.sport = 16'($urandom()); p.dport = port;
        p.ucsum = 16'($urandom());
        return p;
    endfunction

    function automatic pkt_t corrupt(input pkt_t p_in, input int kind);
        pkt_t p;
        p = p_in;
        case (kind)
            1: p.dst_mac = ($urandom_range(0, 1) != 0) ? 48'hFFFF_FFFF_FFFF
                                                       : 48'({$urandom(), $urandom()});
            2: p.etype = 16'($urandom());
            3: p.ver_ihl = 8'($urandom());
            5: case ($urandom_range(0, 2))
                   0: p.frag = p.frag | 16'h2000;
                   1: p.frag = (p.frag & 16'hE000) | 16'($urandom_range(1, 8191));
                   default: p.frag = 16'h4000;
               endcase
            6: p.proto = 8'($urandom());
            7: p.dst_ip = $urandom();
            8: p.dport = 16'($urandom());
            9: if ($urandom_range(0, 1) != 0) begin
                   p.ulen = 16'($urandom_range(0, 7)); p.ip_len = p.ulen + 16'd20;
               end else begin
                   p.ip_len = p.ulen + 16'($urandom_range(21, 60));
               end
            default: ;
        endcase
        return p;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t p;
        int   k1, k2, r, gap;

        i_reset = 1'b1; i_data_head = '0; i_data_head_valid = 1'b0;
        i_local_mac = 48'h02_00_00_00_00_01; i_local_ip = 32'hC0A8_00C7; i_local_port = 16'h1234;
        repeat (3) @(negedge i_clk);
        check_eq("reset_ctrl_a", {vld_a, acc_a, rsn_a, busy_a, ovr_a}, 0);
        check_eq("reset_fields_a", {smac_a, plen_a}, 0);
        check_eq("reset_ipport_a", {sip_a, sport_a, dport_a}, 0);
        i_reset = 1'b0;
        @(negedge i_clk);

        // Known good packet, with busy window and held fields checked
        pulse(pack(plan_pkt()), 1'b1);
        check_eq("busy_cycle1", busy_a, 1);
        repeat (5) @(negedge i_clk);
        check_eq("busy_cycle6", busy_a, 1);
        @(negedge i_clk);
        check_eq("busy_cycle7", busy_a, 0);
        @(negedge i_clk);
        check_eq("held_valid_low", vld_a, 0);
        check_eq("plan_accept", acc_a, 1);
        check_eq("plan_reason", rsn_a, 0);
        check_eq("plan_src_ip", sip_a, 32'hC0A8_0001);
        check_eq("plan_payload_len", plen_a, 16'h0057);

        // Bad checksum
        p = plan_pkt(); p.csum = 16'hB862;
        pulse(pack(p), 1'b1); repeat (7) @(negedge i_clk);
        check_eq("bad_csum_reason", rsn_a, 4);
        // Broadcast: accepted by A, reason 1 on B
        p = plan_pkt(); p.dst_mac = 48'hFFFF_FFFF_FFFF;
        pulse(pack(p), 1'b1); repeat (7) @(negedge i_clk);
        check_eq("bcast_accept_a", acc_a, 1);
        check_eq("bcast_reason_b", rsn_b, 1);
        // Two failures: type wins over port
        p = plan_pkt(); p.etype = 16'h86DD; p.dport = 16'h9999;
        pulse(pack(p), 1'b1); repeat (7) @(negedge i_clk);
        check_eq("priority_reason", rsn_a, 2);

        // Overrun: second pulse 3 cycles after the first
        pulse(pack(plan_pkt()), 1'b1);
        repeat (2) @(negedge i_clk);
        pulse(pack(plan_pkt()), 1'b0);
        repeat (6) @(negedge i_clk);

        // Back-to-back: second pulse in the verdict cycle
        pulse(pack(plan_pkt()), 1'b1);
        repeat (6) @(negedge i_clk);
        p = plan_pkt(); p.proto = 8'h06; p.csum = ip_csum(p);
        pulse(pack(p), 1'b1);
        repeat (7) @(negedge i_clk);

        // Reset in cycle 4 of a parse: no verdict, outputs cleared
        pulse(pack(plan_pkt()), 1'b1);
        repeat (3) @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        check_eq("midreset_ctrl_a", {vld_a, acc_a, rsn_a, busy_a, ovr_a}, 0);
        check_eq("midreset_fields_a", {smac_a, plen_a}, 0);
        check_eq("midreset_ipport_a", {sip_a, sport_a, dport_a}, 0);
        exp_a_q.delete(); exp_b_q.delete();
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        repeat (10) @(negedge i_clk);
        i_local_mac = 48'h02_00_00_00_00_01; i_local_ip = 32'hC0A8_00C7; i_local_port = 16'h1234;
        pulse(pack(plan_pkt()), 1'b1); repeat (7) @(negedge i_clk);
        check_eq("after_reset_accept", acc_a, 1);

        // Randomized headers with single/double corruptions and overrun injection
        for (int n = 0; n < 60; n++) begin
            scramble_locals();
            p = rand_pkt(i_local_mac, i_local_ip, i_local_port);
            k1 = $urandom_range(0, 9);
            k2 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 0;
            p = corrupt(p, k1);
            p = corrupt(p, k2);
            p.csum = ip_csum(p);
            if (k1 == 4 || k2 == 4) p.csum = p.csum ^ (16'h1 << $urandom_range(0, 15));
            pulse(pack(p), 1'b1);
            scramble_locals();
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 5);
                repeat (r) @(negedge i_clk);
                for (int i = 0; i < 11; i++) i_data_head[32*i +: 32] = $urandom();
                pulse(i_data_head, 1'b0);
                gap = 5 - r;
            end else begin
                gap = $urandom_range(6, 9);
            end
            repeat (gap) @(negedge i_clk);
        end

        // Drain with a bounded wait
        for (int t = 0; t < 20 && (exp_a_q.size() + exp_b_q.size() != 0); t++) @(negedge i_clk);
        repeat (2) @(negedge i_clk);
        check_eq("pending_verdicts_a", exp_a_q.size(), 0);
        check_eq("pending_verdicts_b", exp_b_q.size(), 0);
        check_eq("pending_overruns_a", exp_ovr_a_q.size(), 0);
        check_eq("pending_overruns_b", exp_ovr_b_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
